// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls and instruction memory in, PC/instruction/trap status out.
// The master modport is the fetch unit; the slave modport is the core/memory side.
interface pc_fetch_unit_if #(
  parameter int IMEM_AW = 11
);
  logic                stall;
  logic                jump_en;
  logic [31:0]         jump_target;
  logic [31:0]         instr_in;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [31:0]         pc;
  logic [31:0]         pc_plus4;
  logic [31:0]         instr;
  logic                instr_valid;
  logic                fetch_fault;
  logic [31:0]         fault_addr;
  logic [31:0]         instret;

  modport master (
    input  stall, jump_en, jump_target, instr_in,
    output imem_addr, pc, pc_plus4, instr, instr_valid, fetch_fault, fault_addr, instret
  );

  modport slave (
    output stall, jump_en, jump_target, instr_in,
    input  imem_addr, pc, pc_plus4, instr, instr_valid, fetch_fault, fault_addr, instret
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch with BOOT/RUN/TRAP control and fetch-address trapping.
// Optional retired-fetch counter built only when PC_FETCH_INSTRET_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 11
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fault_addr;
  logic        r_fault;
  logic        r_instr_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_cand;
  logic        w_cand_ok;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_cand     = bus.jump_en ? bus.jump_target : w_pc_plus4;
  // Anything outside the word-aligned 2^IMEM_AW-byte window traps instead of aliasing.
  assign w_cand_ok  = (w_cand[1:0] == 2'b00) &&
                      (w_cand[31:IMEM_AW] == {(32-IMEM_AW){1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_fault_addr  <= 32'h0000_0000;
      r_fault       <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state       <= ST_RUN;
          r_instr_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (w_cand_ok) begin
              r_pc <= w_cand;
            end else begin
              r_fault_addr  <= w_cand;
              r_fault       <= 1'b1;
              r_instr_valid <= 1'b0;
              r_state       <= ST_TRAP;
            end
          end
        end
        ST_TRAP: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state       <= ST_TRAP;
          r_fault       <= 1'b1;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 32'h0000_0000;
    end else if ((r_state == ST_RUN) && !bus.stall && w_cand_ok) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign bus.instret = r_instret;
`else
  assign bus.instret = 32'h0000_0000;
`endif

  assign bus.imem_addr   = r_pc[IMEM_AW-1:0];
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr       = r_instr_valid ? bus.instr_in : NOP;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fetch_fault = r_fault;
  assign bus.fault_addr  = r_fault_addr;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle core. Holds the architectural PC, drives the byte address into the 2 KB word-aligned instruction memory, and forwards the returned 32-bit word to decode. Selects the next PC from sequential (+4) or a jump/branch redirect (JAL/JALR/branch target computed downstream). Traps on misaligned or out-of-range fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned and below 2048.
- IMEM_AW, 11: instruction-memory byte-address width; the memory is 2^IMEM_AW bytes.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC this cycle.
- jump_en  in  1  redirect request; the PC loads jump_target this edge.
- jump_target  in  32  redirect byte address (JALR bit-0 clearing is done upstream).
- instr_in  in  32  word returned combinationally by instruction memory.
- imem_addr  out  IMEM_AW  = pc[IMEM_AW-1:0].
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, modulo 2^32 (link value for JAL/JALR).
- instr  out  32  = instr_in when instr_valid, else 32'h0000_0013 (NOP).
- instr_valid  out  1  fetched word is architecturally valid.
- fetch_fault  out  1  sticky trap flag.
- fault_addr  out  32  the offending next-PC that caused the trap.
- instret  out  32  retired-fetch counter (see Configuration).

## Operation
- States: BOOT, RUN, TRAP.
- BOOT: entered on reset. instr_valid = 0, PC held. Moves to RUN unconditionally on the next edge.
- RUN: instr_valid = 1. On each edge, the candidate next PC is selected with this priority:
  - stall = 1: hold the PC; jump_en is ignored. The producer must hold jump_en and jump_target until stall drops.
  - jump_en = 1: the candidate is jump_target.
  - otherwise: the candidate is pc + 4.
- Candidate check: a candidate is illegal if cand[1:0] != 0 or cand[31:IMEM_AW] != 0.
  - Legal candidate: pc <= candidate.
  - Illegal candidate: PC held, fault_addr <= candidate, fetch_fault <= 1, state goes to TRAP.
- TRAP: instr_valid = 0, instr = NOP, PC frozen, stall and jump_en ignored. Only rst exits this state.
- Sequential wrap: pc = 2044 with no jump gives candidate 2048, which is out of range, so the block traps. The PC never wraps to 0 silently.
- Priority: rst > TRAP > stall > jump_en > sequential.

## Timing
- Reset values: pc = RESET_PC, state = BOOT, instr_valid = 0, instr = NOP, fetch_fault = 0, fault_addr = 0, instret = 0. pc_plus4 = RESET_PC + 4 and imem_addr = RESET_PC[IMEM_AW-1:0] (combinational).
- Latency:
  - imem_addr, instr and pc_plus4 are combinational from registered pc.
  - The new PC is visible the cycle after the edge where it was chosen.
  - First valid instruction appears in the second cycle after rst deasserts (one BOOT cycle).
- Redirect has zero bubble: jump_en sampled at edge N puts the target word on instr in cycle N+1.
- rst asserted mid-operation, including in TRAP: all state returns to reset values at that edge, with no partial update.
- Simultaneous stall and jump_en: the PC holds, and the jump takes effect on the first edge with stall = 0.

## Configuration
- PC_FETCH_INSTRET_EN defined:
  - instret increments by 1 on every edge in RUN where stall = 0 and the candidate is legal.
  - It wraps modulo 2^32 and is cleared by rst.
- Not defined: the counter register is not built and instret is tied to 32'h0.

## Test plan
- Reset release with RESET_PC = 0, no stall or jump: cycle 1 gives instr_valid = 0, instr = 32'h13. Cycles 2 to 4 give pc = 0, 4, 8 with instr equal to memory words 0, 1, 2.
- In RUN at pc = 8, jump_en = 1 with jump_target = 32'h40 for one edge: next cycle pc = 32'h40 and pc_plus4 = 32'h44. With PC_FETCH_INSTRET_EN defined, instret advances by 1.
- stall = 1 for 3 cycles at pc = 32'h10, with jump_en = 1 and target 32'h80 during the stall: pc stays 32'h10. On the first edge after stall drops, pc = 32'h80.
- jump_target = 32'h22: fetch_fault = 1 and fault_addr = 32'h22 on the next cycle. pc is held, and instr_valid = 0 with instr = 32'h13 until rst.
- Sequential run to pc = 2044: the next edge traps with fault_addr = 2048. Asserting rst for one cycle clears fetch_fault and restarts from RESET_PC through BOOT.
- Out-of-range jump to 32'h0000_0800: traps, and the PC does not alias to 0.
